// File: rtl/tcp_tx_pattern_gen_pkg.sv
// Shared definitions for the TCP TX pattern generator: register offsets, MODE
// encodings, FSM states, LFSR taps and the pattern next-value helpers.
package tcp_tx_pattern_gen_pkg;

  localparam logic [3:0] OFF_CTRL    = 4'h0;
  localparam logic [3:0] OFF_PATTERN = 4'h1;
  localparam logic [3:0] OFF_LEN3    = 4'h2;
  localparam logic [3:0] OFF_LEN2    = 4'h3;
  localparam logic [3:0] OFF_LEN1    = 4'h4;
  localparam logic [3:0] OFF_LEN0    = 4'h5;
  localparam logic [3:0] OFF_SENT3   = 4'h6;
  localparam logic [3:0] OFF_SENT2   = 4'h7;
  localparam logic [3:0] OFF_SENT1   = 4'h8;
  localparam logic [3:0] OFF_SENT0   = 4'h9;
  localparam logic [3:0] OFF_STATUS  = 4'hA;

  // x^8+x^6+x^5+x^4+1 with a left shift: feedback is the XOR of bits 7,5,4,3
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  typedef enum logic [1:0] {
    MODE_INC   = 2'b00,
    MODE_DEC   = 2'b01,
    MODE_FIXED = 2'b10,
    MODE_LFSR  = 2'b11
  } mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  typedef struct packed {
    logic        cont;
    mode_e       mode;
    logic [7:0]  pattern;
    logic [31:0] length;
  } cfg_t;

  function automatic logic [7:0] pat_next(input mode_e m, input logic [7:0] p);
    logic [7:0] n;
    case (m)
      MODE_INC:   n = p + 8'd1;
      MODE_DEC:   n = p - 8'd1;
      MODE_FIXED: n = p;
      default:    n = {p[6:0], ^(p & LFSR_TAPS)};
    endcase
    return n;
  endfunction

  // an all-zero LFSR state would lock up, so seed 0 becomes 1
  function automatic logic [7:0] pat_seed(input mode_e m, input logic [7:0] v);
    return (m == MODE_LFSR && v == 8'h00) ? 8'h01 : v;
  endfunction

endpackage

// File: rtl/tcp_tx_pattern_gen_src.sv
// Pattern byte source: loads the seed and mode at START, then advances one step
// per transmitted byte.
module tcp_tx_pattern_src
  import tcp_tx_pattern_gen_pkg::*;
(
  input  logic       CLK_200M,
  input  logic       SYS_RSTn,
  input  logic       i_srst,
  input  logic       i_load,
  input  mode_e      i_load_mode,
  input  logic [7:0] i_load_val,
  input  logic       i_adv,
  output logic [7:0] o_pat
);

  logic [7:0] r_pat;
  mode_e      r_mode;

  always_ff @(posedge CLK_200M or negedge SYS_RSTn) begin
    if (!SYS_RSTn) begin
      r_pat  <= 8'h00;
      r_mode <= MODE_INC;
    end else if (i_srst) begin
      r_pat  <= 8'h00;
      r_mode <= MODE_INC;
    end else if (i_load) begin
      r_pat  <= pat_seed(i_load_mode, i_load_val);
      r_mode <= i_load_mode;
    end else if (i_adv) begin
      r_pat  <= pat_next(r_mode, r_pat);
    end
  end

  assign o_pat = r_pat;

endmodule

// File: rtl/tcp_tx_pattern_gen.sv
// Programmable TCP TX byte source for the SiTCP TX FIFO port, configured over
// an RBCP register window; emits N bytes or a continuous stream, honouring TX_FULL.
module tcp_tx_pattern_gen
  import tcp_tx_pattern_gen_pkg::*;
#(
  parameter logic [31:0] RBCP_BASE  = 32'h0000_0100,
  parameter logic [31:0] DEF_LENGTH = 32'd1024
) (
  input  logic        CLK_200M,
  input  logic        SYS_RSTn,
  input  logic        SITCP_RST,
  input  logic        TCP_OPEN_ACK,
  input  logic        TCP_TX_FULL,
  output logic        TCP_TX_WR,
  output logic [7:0]  TCP_TX_DATA,
  input  logic [31:0] RBCP_ADDR,
  input  logic        RBCP_WE,
  input  logic        RBCP_RE,
  input  logic [7:0]  RBCP_WD,
  output logic        RBCP_ACK,
  output logic [7:0]  RBCP_RD,
  output logic        BUSY
);

  localparam cfg_t CFG_RST = '{cont: 1'b0, mode: MODE_INC, pattern: 8'h00, length: DEF_LENGTH};

  cfg_t        r_cfg;
  state_e      r_state;
  state_e      w_state_nxt;
  logic [31:0] r_remain;
  logic [31:0] r_sent;
  logic [31:0] r_sent_snap;
  logic        r_run_cont;
  logic        r_done;
  logic        r_aborted;
  logic        r_tx_wr;
  logic [7:0]  r_tx_data;
  logic        r_ack;
  logic [7:0]  r_rd;

  logic [31:0] w_off;
  logic [3:0]  w_reg;
  logic        w_hit;
  logic        w_wr;
  logic        w_rdn;
  logic        w_start;
  logic        w_abort_req;
  logic        w_go;
  logic        w_zero;
  logic        w_abort;
  logic        w_fin;
  logic        w_issue;
  logic        w_busy;
  logic [7:0]  w_pat;
  logic [7:0]  w_status;
  logic [7:0]  w_rd_mux;
  logic        w_unused_wd;

  // window hit is computed on the offset so any 16-byte aligned base works
  assign w_off       = RBCP_ADDR - RBCP_BASE;
  assign w_reg       = w_off[3:0];
  assign w_hit       = (w_off[31:4] == 28'd0);
  assign w_wr        = RBCP_WE & w_hit;
  assign w_rdn       = RBCP_RE & w_hit & ~RBCP_WE;
  assign w_start     = w_wr & (w_reg == OFF_CTRL) & RBCP_WD[0];
  assign w_abort_req = w_wr & (w_reg == OFF_CTRL) & RBCP_WD[2];
  assign w_busy      = (r_state == ST_RUN);
  assign w_status    = {4'b0000, TCP_OPEN_ACK, r_aborted, r_done, w_busy};
  assign w_unused_wd = ^{RBCP_WD[7:6], RBCP_WD[3]};

  always_comb begin
    w_state_nxt = r_state;
    w_go        = 1'b0;
    w_zero      = 1'b0;
    w_abort     = 1'b0;
    w_fin       = 1'b0;
    w_issue     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_start && TCP_OPEN_ACK) begin
          if (RBCP_WD[1] || r_cfg.length != 32'd0) begin
            w_go        = 1'b1;
            w_state_nxt = ST_RUN;
          end else begin
            w_zero = 1'b1;
          end
        end
      end
      default: begin
        if (w_abort_req || !TCP_OPEN_ACK) begin
          w_abort     = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (!r_run_cont && r_remain == 32'd0) begin
          w_fin       = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_issue = ~TCP_TX_FULL;
        end
      end
    endcase
  end

  always_ff @(posedge CLK_200M or negedge SYS_RSTn) begin
    if (!SYS_RSTn) begin
      r_state <= ST_IDLE;
    end else if (SITCP_RST) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge CLK_200M or negedge SYS_RSTn) begin
    if (!SYS_RSTn) begin
      r_cfg <= CFG_RST;
    end else if (SITCP_RST) begin
      r_cfg <= CFG_RST;
    end else if (w_wr) begin
      case (w_reg)
        OFF_CTRL: begin
          r_cfg.cont <= RBCP_WD[1];
          r_cfg.mode <= mode_e'(RBCP_WD[5:4]);
        end
        OFF_PATTERN: r_cfg.pattern        <= RBCP_WD;
        OFF_LEN3:    r_cfg.length[31:24]  <= RBCP_WD;
        OFF_LEN2:    r_cfg.length[23:16]  <= RBCP_WD;
        OFF_LEN1:    r_cfg.length[15:8]   <= RBCP_WD;
        OFF_LEN0:    r_cfg.length[7:0]    <= RBCP_WD;
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK_200M or negedge SYS_RSTn) begin
    if (!SYS_RSTn) begin
      r_remain   <= 32'd0;
      r_sent     <= 32'd0;
      r_run_cont <= 1'b0;
      r_done     <= 1'b0;
      r_aborted  <= 1'b0;
      r_tx_wr    <= 1'b0;
      r_tx_data  <= 8'h00;
    end else if (SITCP_RST) begin
      r_remain   <= 32'd0;
      r_sent     <= 32'd0;
      r_run_cont <= 1'b0;
      r_done     <= 1'b0;
      r_aborted  <= 1'b0;
      r_tx_wr    <= 1'b0;
      r_tx_data  <= 8'h00;
    end else begin
      r_tx_wr <= w_issue;
      if (w_issue) begin
        r_tx_data <= w_pat;
        r_sent    <= r_sent + 32'd1;
        if (!r_run_cont) r_remain <= r_remain - 32'd1;
      end
      // CONT is captured at START so a later CTRL write (e.g. ABORT) cannot change a live run
      if (w_go) begin
        r_remain   <= r_cfg.length;
        r_run_cont <= RBCP_WD[1];
        r_sent     <= 32'd0;
        r_done     <= 1'b0;
        r_aborted  <= 1'b0;
      end
      if (w_zero) begin
        r_sent    <= 32'd0;
        r_done    <= 1'b1;
        r_aborted <= 1'b0;
      end
      if (w_fin)   r_done    <= 1'b1;
      if (w_abort) r_aborted <= 1'b1;
    end
  end

  tcp_tx_pattern_src u_src (
    .CLK_200M    (CLK_200M),
    .SYS_RSTn    (SYS_RSTn),
    .i_srst      (SITCP_RST),
    .i_load      (w_go),
    .i_load_mode (mode_e'(RBCP_WD[5:4])),
    .i_load_val  (r_cfg.pattern),
    .i_adv       (w_issue),
    .o_pat       (w_pat)
  );

  always_comb begin
    w_rd_mux = 8'h00;
    case (w_reg)
      OFF_CTRL:    w_rd_mux = {2'b00, r_cfg.mode, 2'b00, r_cfg.cont, 1'b0};
      OFF_PATTERN: w_rd_mux = r_cfg.pattern;
      OFF_LEN3:    w_rd_mux = r_cfg.length[31:24];
      OFF_LEN2:    w_rd_mux = r_cfg.length[23:16];
      OFF_LEN1:    w_rd_mux = r_cfg.length[15:8];
      OFF_LEN0:    w_rd_mux = r_cfg.length[7:0];
      OFF_SENT3:   w_rd_mux = r_sent[31:24];
      OFF_SENT2:   w_rd_mux = r_sent_snap[23:16];
      OFF_SENT1:   w_rd_mux = r_sent_snap[15:8];
      OFF_SENT0:   w_rd_mux = r_sent_snap[7:0];
      OFF_STATUS:  w_rd_mux = w_status;
      default:     w_rd_mux = 8'h00;
    endcase
  end

  // reading the SENT MSB freezes the lower bytes so a 4-byte read is coherent
  always_ff @(posedge CLK_200M or negedge SYS_RSTn) begin
    if (!SYS_RSTn) begin
      r_ack       <= 1'b0;
      r_rd        <= 8'h00;
      r_sent_snap <= 32'd0;
    end else if (SITCP_RST) begin
      r_ack       <= 1'b0;
      r_rd        <= 8'h00;
      r_sent_snap <= 32'd0;
    end else begin
      r_ack <= w_wr | w_rdn;
      r_rd  <= w_rdn ? w_rd_mux : 8'h00;
      if (w_rdn && w_reg == OFF_SENT3) r_sent_snap <= r_sent;
    end
  end

  assign TCP_TX_WR   = r_tx_wr;
  assign TCP_TX_DATA = r_tx_data;
  assign RBCP_ACK    = r_ack;
  assign RBCP_RD     = r_rd;
  assign BUSY        = w_busy;

endmodule

// File: tb/tb_tcp_tx_pattern_gen.sv
// Directed bench for tcp_tx_pattern_gen: byte stream capture plus RBCP register checks.
`timescale 1ns/1ps
module tb_tcp_tx_pattern_gen;

  logic        CLK_200M = 1'b0;
  logic        SYS_RSTn = 1'b0;
  logic        SITCP_RST = 1'b0;
  logic        TCP_OPEN_ACK = 1'b1;
  logic        TCP_TX_FULL = 1'b0;
  logic        TCP_TX_WR;
  logic [7:0]  TCP_TX_DATA;
  logic [31:0] RBCP_ADDR = 32'h0;
  logic        RBCP_WE = 1'b0;
  logic        RBCP_RE = 1'b0;
  logic [7:0]  RBCP_WD = 8'h00;
  logic        RBCP_ACK;
  logic [7:0]  RBCP_RD;
  logic        BUSY;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int last_we_cyc = 0;
  logic [7:0] tx_q[$];
  int         tx_cyc[$];
  int         wr_while_full = 0;
  int         wr_in_full = 0;
  int         busy_cycles = 0;
  logic       full_prev = 1'b0;

  tcp_tx_pattern_gen dut (
    .CLK_200M(CLK_200M), .SYS_RSTn(SYS_RSTn), .SITCP_RST(SITCP_RST),
    .TCP_OPEN_ACK(TCP_OPEN_ACK), .TCP_TX_FULL(TCP_TX_FULL),
    .TCP_TX_WR(TCP_TX_WR), .TCP_TX_DATA(TCP_TX_DATA),
    .RBCP_ADDR(RBCP_ADDR), .RBCP_WE(RBCP_WE), .RBCP_RE(RBCP_RE), .RBCP_WD(RBCP_WD),
    .RBCP_ACK(RBCP_ACK), .RBCP_RD(RBCP_RD), .BUSY(BUSY)
  );

  always #2.5 CLK_200M = ~CLK_200M;
  always @(posedge CLK_200M) cyc <= cyc + 1;

  always @(negedge CLK_200M) begin
    if (TCP_TX_WR) begin
      tx_q.push_back(TCP_TX_DATA);
      tx_cyc.push_back(cyc);
      if (full_prev) wr_while_full = wr_while_full + 1;
      if (TCP_TX_FULL) wr_in_full = wr_in_full + 1;
    end
    if (BUSY) busy_cycles = busy_cycles + 1;
    full_prev = TCP_TX_FULL;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge CLK_200M);
    #1;
  endtask

  task automatic rbcp_write(input logic [31:0] a, input logic [7:0] d);
    @(posedge CLK_200M); #1;
    RBCP_ADDR = a; RBCP_WD = d; RBCP_WE = 1'b1;
    @(posedge CLK_200M); #1;
    RBCP_WE = 1'b0;
    last_we_cyc = cyc;
  endtask

  task automatic rbcp_read(input logic [31:0] a, output logic [7:0] d, output logic ack);
    @(posedge CLK_200M); #1;
    RBCP_ADDR = a; RBCP_RE = 1'b1;
    @(posedge CLK_200M); #1;
    RBCP_RE = 1'b0;
    ack = RBCP_ACK;
    d = RBCP_RD;
  endtask

  task automatic read_sent(output logic [31:0] s);
    logic [7:0] b;
    logic a;
    rbcp_read(32'h106, b, a); s[31:24] = b;
    rbcp_read(32'h107, b, a); s[23:16] = b;
    rbcp_read(32'h108, b, a); s[15:8]  = b;
    rbcp_read(32'h109, b, a); s[7:0]   = b;
  endtask

  task automatic test_reset();
    logic [7:0] d;
    logic a;
    tests++; if (TCP_TX_WR !== 1'b0) begin fails++; $display("FAIL reset_tx_wr: got %b want 0", TCP_TX_WR); end
    tests++; if (BUSY !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", BUSY); end
    tests++; if (RBCP_ACK !== 1'b0 || RBCP_RD !== 8'h00) begin fails++; $display("FAIL reset_rbcp: ack %b rd %h want 0 00", RBCP_ACK, RBCP_RD); end
    rbcp_read(32'h104, d, a);
    tests++; if (a !== 1'b1 || d !== 8'h04) begin fails++; $display("FAIL reset_len1: ack %b rd %h want 1 04", a, d); end
    rbcp_read(32'h105, d, a);
    tests++; if (d !== 8'h00) begin fails++; $display("FAIL reset_len0: got %h want 00", d); end
    rbcp_read(32'h100, d, a);
    tests++; if (d !== 8'h00) begin fails++; $display("FAIL reset_ctrl: got %h want 00", d); end
    rbcp_read(32'h10A, d, a);
    tests++; if (d !== 8'h08) begin fails++; $display("FAIL reset_status: got %h want 08", d); end
  endtask

  task automatic test_inc();
    logic [7:0] exp [5];
    logic [7:0] d;
    logic [31:0] s;
    logic a;
    int n0;
    exp = '{8'hFE, 8'hFF, 8'h00, 8'h01, 8'h02};
    rbcp_write(32'h104, 8'h00);
    rbcp_write(32'h105, 8'd5);
    rbcp_write(32'h101, 8'hFE);
    n0 = tx_q.size();
    rbcp_write(32'h100, 8'h01);
    tick(20);
    tests++; if (tx_q.size() - n0 !== 5) begin fails++; $display("FAIL inc_count: got %0d want 5", tx_q.size() - n0); end
    if (tx_q.size() - n0 >= 5) begin
      for (int i = 0; i < 5; i++) begin
        tests++; if (tx_q[n0+i] !== exp[i]) begin fails++; $display("FAIL inc_byte%0d: got %h want %h", i, tx_q[n0+i], exp[i]); end
      end
      tests++; if (tx_cyc[n0+4] - tx_cyc[n0] !== 4) begin fails++; $display("FAIL inc_consecutive: span %0d want 4", tx_cyc[n0+4] - tx_cyc[n0]); end
    end
    rbcp_read(32'h10A, d, a);
    tests++; if (d !== 8'h0A) begin fails++; $display("FAIL inc_status: got %h want 0a", d); end
    read_sent(s);
    tests++; if (s !== 32'd5) begin fails++; $display("FAIL inc_sent: got %0d want 5", s); end
  endtask

  task automatic test_lfsr();
    logic [7:0] exp [8];
    logic [7:0] d;
    logic a;
    int n0;
    exp = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11, 8'h23, 8'h47, 8'h8E};
    rbcp_write(32'h105, 8'd8);
    rbcp_write(32'h101, 8'h00);
    n0 = tx_q.size();
    rbcp_write(32'h100, 8'h31);
    tick(20);
    tests++; if (tx_q.size() - n0 !== 8) begin fails++; $display("FAIL lfsr_count: got %0d want 8", tx_q.size() - n0); end
    if (tx_q.size() - n0 >= 8) begin
      for (int i = 0; i < 8; i++) begin
        tests++; if (tx_q[n0+i] !== exp[i]) begin fails++; $display("FAIL lfsr_byte%0d: got %h want %h", i, tx_q[n0+i], exp[i]); end
      end
    end
    rbcp_read(32'h10A, d, a);
    tests++; if (d !== 8'h0A) begin fails++; $display("FAIL lfsr_status: got %h want 0a", d); end
  endtask

  task automatic test_full();
    int n0, f0, g0, bad;
    rbcp_write(32'h105, 8'd100);
    rbcp_write(32'h101, 8'h00);
    n0 = tx_q.size(); f0 = wr_while_full; g0 = wr_in_full;
    rbcp_write(32'h100, 8'h01);
    for (int k = 0; k < 160; k++) begin
      if (k == 10) TCP_TX_FULL = 1'b1;
      if (k == 30) TCP_TX_FULL = 1'b0;
      tick(1);
    end
    tests++; if (wr_while_full - f0 !== 0) begin fails++; $display("FAIL full_held_writes: got %0d want 0", wr_while_full - f0); end
    tests++; if (wr_in_full - g0 > 1) begin fails++; $display("FAIL full_after_rise: got %0d want <=1", wr_in_full - g0); end
    tests++; if (tx_q.size() - n0 !== 100) begin fails++; $display("FAIL full_count: got %0d want 100", tx_q.size() - n0); end
    bad = 0;
    for (int i = 0; i < 100 && n0 + i < tx_q.size(); i++)
      if (tx_q[n0+i] !== 8'(i)) bad++;
    tests++; if (bad !== 0) begin fails++; $display("FAIL full_sequence: %0d bad bytes want 0", bad); end
    tests++; if (BUSY !== 1'b0) begin fails++; $display("FAIL full_busy_end: got %b want 0", BUSY); end
  endtask

  task automatic test_cont_abort();
    logic [7:0] d;
    logic [31:0] s;
    logic a;
    int n0, n, guard;
    rbcp_write(32'h101, 8'h00);
    n0 = tx_q.size();
    rbcp_write(32'h100, 8'h03);
    guard = 0;
    while (tx_q.size() - n0 < 1000 && guard < 3000) begin tick(1); guard++; end
    tests++; if (guard >= 3000) begin fails++; $display("FAIL cont_timeout: got %0d bytes want 1000", tx_q.size() - n0); end
    rbcp_write(32'h100, 8'h06);
    tick(10);
    n = tx_q.size() - n0;
    tests++; if (tx_cyc[tx_cyc.size()-1] > last_we_cyc + 1) begin fails++; $display("FAIL abort_stop: last wr cyc %0d abort cyc %0d", tx_cyc[tx_cyc.size()-1], last_we_cyc); end
    tests++; if (BUSY !== 1'b0) begin fails++; $display("FAIL abort_busy: got %b want 0", BUSY); end
    rbcp_read(32'h10A, d, a);
    tests++; if (d !== 8'h0C) begin fails++; $display("FAIL abort_status: got %h want 0c", d); end
    read_sent(s);
    tests++; if (s !== 32'(n)) begin fails++; $display("FAIL abort_sent: got %0d want %0d", s, n); end
    tests++; if (tx_q.size() - n0 !== n) begin fails++; $display("FAIL abort_quiet: got %0d want %0d", tx_q.size() - n0, n); end
    tests++; if (tx_q[tx_q.size()-1] !== 8'(n - 1)) begin fails++; $display("FAIL abort_lastbyte: got %h want %h", tx_q[tx_q.size()-1], 8'(n - 1)); end
  endtask

  task automatic test_openack_drop();
    logic [7:0] d;
    logic a;
    int n1, b0;
    rbcp_write(32'h100, 8'h03);
    tick(20);
    TCP_OPEN_ACK = 1'b0;
    tick(5);
    n1 = tx_q.size();
    tick(10);
    tests++; if (tx_q.size() !== n1) begin fails++; $display("FAIL drop_quiet: got %0d want %0d", tx_q.size(), n1); end
    tests++; if (BUSY !== 1'b0) begin fails++; $display("FAIL drop_busy: got %b want 0", BUSY); end
    rbcp_read(32'h10A, d, a);
    tests++; if (d !== 8'h04) begin fails++; $display("FAIL drop_status: got %h want 04", d); end
    b0 = busy_cycles; n1 = tx_q.size();
    rbcp_write(32'h100, 8'h01);
    tick(10);
    tests++; if (tx_q.size() !== n1) begin fails++; $display("FAIL noack_bytes: got %0d want %0d", tx_q.size(), n1); end
    tests++; if (busy_cycles !== b0) begin fails++; $display("FAIL noack_busy: got %0d busy cycles want 0", busy_cycles - b0); end
    TCP_OPEN_ACK = 1'b1;
  endtask

  task automatic test_rbcp();
    logic [7:0] d;
    logic a, a1, a2;
    rbcp_read(32'h10F, d, a);
    tests++; if (a !== 1'b1 || d !== 8'h00) begin fails++; $display("FAIL rbcp_10f: ack %b rd %h want 1 00", a, d); end
    rbcp_read(32'h110, d, a);
    tests++; if (a !== 1'b0 || d !== 8'h00) begin fails++; $display("FAIL rbcp_110: ack %b rd %h want 0 00", a, d); end
    rbcp_read(32'h0FF, d, a);
    tests++; if (a !== 1'b0) begin fails++; $display("FAIL rbcp_0ff: ack %b want 0", a); end
    @(posedge CLK_200M); #1;
    RBCP_ADDR = 32'h101; RBCP_WD = 8'h5A; RBCP_WE = 1'b1; RBCP_RE = 1'b1;
    @(posedge CLK_200M); #1;
    RBCP_WE = 1'b0; RBCP_RE = 1'b0;
    a1 = RBCP_ACK;
    @(posedge CLK_200M); #1;
    a2 = RBCP_ACK;
    tests++; if (a1 !== 1'b1 || a2 !== 1'b0) begin fails++; $display("FAIL rbcp_we_re_ack: acks %b%b want 10", a1, a2); end
    rbcp_read(32'h101, d, a);
    tests++; if (d !== 8'h5A) begin fails++; $display("FAIL rbcp_we_re_data: got %h want 5a", d); end
  endtask

  task automatic test_zero_len();
    logic [7:0] d;
    logic a;
    int n0;
    rbcp_write(32'h104, 8'h00);
    rbcp_write(32'h105, 8'h00);
    n0 = tx_q.size();
    rbcp_write(32'h100, 8'h01);
    tick(5);
    tests++; if (tx_q.size() !== n0) begin fails++; $display("FAIL zero_bytes: got %0d want 0", tx_q.size() - n0); end
    rbcp_read(32'h10A, d, a);
    tests++; if (d !== 8'h0A) begin fails++; $display("FAIL zero_status: got %h want 0a", d); end
  endtask

  task automatic test_sitcp_rst();
    logic [7:0] d;
    logic a;
    rbcp_write(32'h100, 8'h03);
    tick(10);
    tests++; if (TCP_TX_WR !== 1'b1) begin fails++; $display("FAIL srst_running: got %b want 1", TCP_TX_WR); end
    SITCP_RST = 1'b1;
    tick(1);
    SITCP_RST = 1'b0;
    tests++; if (TCP_TX_WR !== 1'b0 || BUSY !== 1'b0) begin fails++; $display("FAIL srst_stop: wr %b busy %b want 0 0", TCP_TX_WR, BUSY); end
    rbcp_read(32'h104, d, a);
    tests++; if (d !== 8'h04) begin fails++; $display("FAIL srst_len: got %h want 04", d); end
    rbcp_read(32'h101, d, a);
    tests++; if (d !== 8'h00) begin fails++; $display("FAIL srst_pattern: got %h want 00", d); end
  endtask

  initial begin
    tick(3);
    SYS_RSTn = 1'b1;
    tick(2);
    test_reset();
    test_inc();
    test_lfsr();
    test_full();
    test_cont_abort();
    test_openack_drop();
    test_rbcp();
    test_zero_len();
    test_sitcp_rst();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
